mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 The module SHALL have parameter TAG_WIDTH, default 6, meaning ROB tag width.
REQ-004 The module SHALL have port clk  input  1  single clock, all state on posedge; the module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have request ports req_valid in 1, req_ready out 1, req_op in mem_op_t (LB, LH, LW, LBU, LHU, SB, SH, SW), req_addr in ADDR_WIDTH, req_wdata in DATA_WIDTH, and req_tag in TAG_WIDTH.
REQ-006 The module SHALL have response ports resp_valid out 1, resp_ready in 1, resp_tag out TAG_WIDTH, resp_data out DATA_WIDTH, and resp_exc out 1 (misaligned access).
REQ-007 The module SHALL have memory ports mem_write_en out 1, waddr out ADDR_WIDTH, wdata out DATA_WIDTH, mem_rd_en out 1, raddr out ADDR_WIDTH, rdata in DATA_WIDTH, and rdata_valid in 1.
REQ-008 The module SHALL have port flush  input  1  which discards any pending load.

Function
REQ-009 The FSM states SHALL be IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, and RESP.
REQ-010 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a posedge with req_valid&&req_ready, and its op, addr, wdata, and tag SHALL be latched.
REQ-011 Every memory access SHALL use the latched byte address unmodified; the memory returns or writes the 4-byte window addr..addr+3, and byte 0 of that window is the target byte.
REQ-012 For loads and for SB/SH, IDLE SHALL transition to RD_ISSUE; for SW, IDLE SHALL transition to WR_ISSUE.
REQ-013 In RD_ISSUE, mem_rd_en SHALL be 1 and raddr SHALL equal the address for exactly one cycle, and the next state SHALL be RD_WAIT.
REQ-014 In RD_WAIT, the unit SHALL hold until rdata_valid=1 and then capture rdata.
REQ-015 On rdata capture for a load, the state SHALL go to RESP.
REQ-016 On rdata capture for SB/SH, the state SHALL go to WR_ISSUE with merged data {rdata[31:8],wdata[7:0]} (SB) or {rdata[31:16],wdata[15:0]} (SH).
REQ-017 In WR_ISSUE, mem_write_en SHALL be 1 for exactly one cycle with waddr and wdata (merged or full word), and the next state SHALL be RESP.
REQ-018 Load data in RESP SHALL be: LB = sext(byte0), LBU = zext(byte0), LH = sext(bytes1:0), LHU = zext(bytes1:0), LW = full word; for stores, resp_data SHALL be 0.
REQ-019 In RESP, resp_valid SHALL be 1 and resp_data, resp_tag, and resp_exc SHALL be held stable until resp_ready=1; the handshake cycle SHALL return the FSM to IDLE.
REQ-020 Latency with resp_ready tied high and memory latency of 1 cycle SHALL be: LW 3 cycles accept-to-resp_valid, SW 2, SB/SH 4.
REQ-021 mem_rd_en and mem_write_en SHALL never both be 1 in the same cycle.
REQ-022 When flush=1 in RD_ISSUE or RD_WAIT of a load, the FSM SHALL go to IDLE next cycle with no response, and a later stale rdata_valid SHALL be ignored.
REQ-023 flush SHALL be ignored for stores and in RESP; a committed store always completes.
REQ-024 When flush and an accept coincide in IDLE, the request SHALL NOT be accepted.

Reset
REQ-025 On rst=1 at posedge, the FSM SHALL go to IDLE and req_ready SHALL be 1 after reset.
REQ-026 On reset, resp_valid, mem_rd_en, mem_write_en, and resp_exc SHALL be 0, and resp_data, resp_tag, waddr, raddr, and wdata SHALL be 0.
REQ-027 Reset mid-operation SHALL abandon the access with no memory write issued afterwards.

Configuration
REQ-028 With macro MEM_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]!=0 and LW/SW with addr[1:0]!=0 SHALL skip memory and go from IDLE directly to RESP with resp_exc=1, resp_data=0, and a latency of 1 cycle.
REQ-029 Without MEM_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed per REQ-011, and resp_exc SHALL be constant 0.

Structure
REQ-030 mem_op_t (3-bit enum), and constants MEM_OP_IS_STORE/size helpers, SHALL reside in parameter_pkg.
REQ-031 One sub-module, load_extend, SHALL be instantiated as a combinational op+rdata to resp_data formatter; the FSM SHALL stay in mem_access_unit.

Verification
REQ-032 The bench SHALL cover: memory word at 0x40 = 0x8899AABB, LW 0x40 tag 5 -> resp_data 0x8899AABB, tag 5, resp_valid 3 cycles after accept.
REQ-033 The bench SHALL cover: same memory, LB 0x40 -> 0xFFFFFFBB; LBU 0x40 -> 0x000000BB; LH 0x42 (trap disabled) -> 0xFFFF8899.
REQ-034 The bench SHALL cover: SB 0x40 wdata 0x12 -> one mem_rd_en, then one mem_write_en with wdata 0x8899AA12, and memory word reads back 0x8899AA12.
REQ-035 The bench SHALL cover: LW issued, flush asserted during RD_WAIT -> no resp_valid; the next SW 0x44 0xDEADBEEF -> single write, resp_valid after 2 cycles.
REQ-036 The bench SHALL cover: resp_ready held low 5 cycles -> resp_valid/resp_data stable, req_ready=0 throughout.
REQ-037 The bench SHALL cover: with MEM_MISALIGN_TRAP_EN defined, SW 0x41 -> resp_exc=1 next cycle, and mem_write_en never asserted.

Source files
------------

// File: rtl/parameter_pkg.sv
// rtl/parameter_pkg.sv - memory op encoding, FSM states and op classification helpers
package parameter_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        RESP     = 3'd4
    } mau_state_t;

    // Bit n set means op encoding n is a store.
    localparam logic [7:0] MEM_OP_IS_STORE = 8'b1110_0000;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    function automatic logic mem_op_is_store(input mem_op_t op);
        return MEM_OP_IS_STORE[op];
    endfunction

    function automatic logic [1:0] mem_op_size(input mem_op_t op);
        case (op)
            LB, LBU, SB: return MEM_SIZE_B;
            LH, LHU, SH: return MEM_SIZE_H;
            default:     return MEM_SIZE_W;
        endcase
    endfunction

    // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
    function automatic logic mem_op_misaligned(input mem_op_t op, input logic [1:0] lsb);
        case (mem_op_size(op))
            MEM_SIZE_H: return lsb[0];
            MEM_SIZE_W: return |lsb;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, response and memory port bundle of the memory access unit
interface mem_access_unit_if import parameter_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
);
    logic                  req_valid;
    logic                  req_ready;
    mem_op_t               req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_exc;

    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;

    // Unit side.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_tag,
        input  resp_ready, rdata, rdata_valid,
        output req_ready, resp_valid, resp_tag, resp_data, resp_exc,
        output mem_write_en, waddr, wdata, mem_rd_en, raddr
    );

    // Requester / memory side.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_tag,
        output resp_ready, rdata, rdata_valid,
        input  req_ready, resp_valid, resp_tag, resp_data, resp_exc,
        input  mem_write_en, waddr, wdata, mem_rd_en, raddr
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - formats the 4-byte read window into load result by op
module load_extend import parameter_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  mem_op_t               i_op,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_data
);

    // Byte 0 of the window is the target; extend byte/halfword to full width.
    always_comb begin
        o_data = i_rdata;
        case (i_op)
            LB:      o_data = {{(DATA_WIDTH-8){i_rdata[7]}}, i_rdata[7:0]};
            LBU:     o_data = {{(DATA_WIDTH-8){1'b0}}, i_rdata[7:0]};
            LH:      o_data = {{(DATA_WIDTH-16){i_rdata[15]}}, i_rdata[15:0]};
            LHU:     o_data = {{(DATA_WIDTH-16){1'b0}}, i_rdata[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store FSM with read-modify-write sub-word stores; MEM_MISALIGN_TRAP_EN enables misalignment trap
module mem_access_unit import parameter_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    mem_access_unit_if.slave  bus
);

    mau_state_t            r_state;
    mau_state_t            w_next_state;
    mem_op_t               r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_stale;

    logic                  w_accept;
    logic                  w_flush_rd;
    logic                  w_capture;
    logic                  w_misaligned;
    logic                  w_exc;
    logic [DATA_WIDTH-1:0] w_ext;

`ifdef MEM_MISALIGN_TRAP_EN
    logic                  r_exc;
    assign w_misaligned = mem_op_misaligned(bus.req_op, bus.req_addr[1:0]);
    assign w_exc        = r_exc;
`else
    assign w_misaligned = 1'b0;
    assign w_exc        = 1'b0;
`endif

    // A flush in IDLE blocks acceptance so the flushed-away request never enters.
    assign w_accept   = (r_state == IDLE) && bus.req_valid && !flush;
    // Only loads are cancellable; committed stores always complete.
    assign w_flush_rd = flush && !mem_op_is_store(r_op)
                        && ((r_state == RD_ISSUE) || (r_state == RD_WAIT));
    // Data belonging to a read abandoned by flush is dropped, not captured.
    assign w_capture  = (r_state == RD_WAIT) && bus.rdata_valid && !r_stale;

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .i_op    (r_op),
        .i_rdata (r_rdata),
        .o_data  (w_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and port outputs.
    always_comb begin
        w_next_state     = r_state;
        bus.req_ready    = 1'b0;
        bus.mem_rd_en    = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.raddr        = r_addr;
        bus.waddr        = r_addr;
        bus.wdata        = r_wdata;
        bus.resp_tag     = r_tag;
        bus.resp_exc     = w_exc;
        bus.resp_data    = (mem_op_is_store(r_op) || w_exc) ? '0 : w_ext;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    if (w_misaligned)         w_next_state = RESP;
                    else if (bus.req_op == SW) w_next_state = WR_ISSUE;
                    else                       w_next_state = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                bus.mem_rd_en = 1'b1;
                w_next_state  = w_flush_rd ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (w_flush_rd)     w_next_state = IDLE;
                else if (w_capture) w_next_state = mem_op_is_store(r_op) ? WR_ISSUE : RESP;
            end
            WR_ISSUE: begin
                bus.mem_write_en = 1'b1;
                w_next_state     = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch, read capture with sub-word merge, and stale-read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= LB;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_tag   <= '0;
            r_stale <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_exc   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op    <= bus.req_op;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_tag   <= bus.req_tag;
`ifdef MEM_MISALIGN_TRAP_EN
                r_exc   <= w_misaligned;
`endif
            end
            if (w_capture && !w_flush_rd) begin
                r_rdata <= bus.rdata;
                if (r_op == SB)
                    r_wdata <= {bus.rdata[DATA_WIDTH-1:8], r_wdata[7:0]};
                else if (r_op == SH)
                    r_wdata <= {bus.rdata[DATA_WIDTH-1:16], r_wdata[15:0]};
            end
            // A read flushed before its data returned leaves one response in flight.
            if (w_flush_rd)
                r_stale <= (r_state == RD_ISSUE) ? 1'b1 : !w_capture;
            else if (bus.rdata_valid && r_stale)
                r_stale <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
`timescale 1ns/1ps
module tb_mem_access_unit;
    import parameter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) bus ();

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Byte-addressed memory, 1-cycle read latency, 4-byte little-endian window.
    logic [7:0]  mem [0:255];
    logic        pl_we, pl_clr;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [7:0]  ra, wa;
    assign ra = bus.raddr[7:0];
    assign wa = bus.waddr[7:0];

    always @(posedge clk) begin
        bus.rdata_valid <= 1'b0;
        if (pl_clr)
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        if (pl_we)
            for (int k = 0; k < 4; k++) mem[pl_addr + 8'(k)] <= pl_data[8*k +: 8];
        if (bus.mem_rd_en) begin
            rd_cnt          <= rd_cnt + 1;
            bus.rdata       <= {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
            bus.rdata_valid <= 1'b1;
        end
        if (bus.mem_write_en) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= bus.waddr;
            last_wdata <= bus.wdata;
            for (int k = 0; k < 4; k++) mem[wa + 8'(k)] <= bus.wdata[8*k +: 8];
        end
        if (bus.mem_rd_en && bus.mem_write_en) both_cnt <= both_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    // Presents one request from IDLE; returns posedges from accept (inclusive) to resp_valid.
    task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                         input logic [5:0] t, output int lat);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_tag   = t;
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic xact(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                        input logic [5:0] t, output int lat, output logic [31:0] data,
                        output logic [5:0] rtag, output logic exc);
        issue(op, a, d, t, lat);
        data = bus.resp_data;
        rtag = bus.resp_tag;
        exc  = bus.resp_exc;
        tick();
    endtask

    int          lat, rd0, wr0;
    logic [31:0] data;
    logic [5:0]  rtag;
    logic        exc;

    initial begin
        rst = 1'b1; flush = 1'b0; pl_we = 1'b0; pl_clr = 1'b1;
        pl_addr = '0; pl_data = '0;
        bus.req_valid = 1'b0; bus.req_op = LB; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_tag = '0; bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; pl_clr = 1'b0;

        chk("rst_req_ready",  32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rd_wr_exc",  {29'd0, bus.mem_rd_en, bus.mem_write_en, bus.resp_exc}, 32'd0);
        chk("rst_resp_data",  bus.resp_data, 32'd0);
        chk("rst_resp_tag",   32'(bus.resp_tag), 32'd0);
        chk("rst_addrs",      bus.waddr | bus.raddr, 32'd0);
        chk("rst_wdata",      bus.wdata, 32'd0);

        preload(8'h40, 32'h8899AABB);

        xact(LW, 32'h40, 32'h0, 6'd5, lat, data, rtag, exc);
        chk("lw_data", data, 32'h8899AABB);
        chk("lw_tag",  32'(rtag), 32'd5);
        chk("lw_lat",  32'(lat), 32'd3);
        chk("lw_exc",  32'(exc), 32'd0);

        xact(LB, 32'h40, 32'h0, 6'd1, lat, data, rtag, exc);
        chk("lb_data", data, 32'hFFFFFFBB);
        xact(LBU, 32'h40, 32'h0, 6'd2, lat, data, rtag, exc);
        chk("lbu_data", data, 32'h000000BB);
        chk("lbu_tag", 32'(rtag), 32'd2);
        xact(LHU, 32'h40, 32'h0, 6'd3, lat, data, rtag, exc);
        chk("lhu_data", data, 32'h0000AABB);

        xact(LH, 32'h42, 32'h0, 6'd4, lat, data, rtag, exc);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lh42_trap_data", data, 32'h0);
        chk("lh42_trap_exc",  32'(exc), 32'd1);
        chk("lh42_trap_lat",  32'(lat), 32'd1);
`else
        chk("lh42_data", data, 32'hFFFF8899);
        chk("lh42_exc",  32'(exc), 32'd0);
`endif

        rd0 = rd_cnt; wr0 = wr_cnt;
        xact(SB, 32'h40, 32'h12, 6'd6, lat, data, rtag, exc);
        chk("sb_rd_count", 32'(rd_cnt - rd0), 32'd1);
        chk("sb_wr_count", 32'(wr_cnt - wr0), 32'd1);
        chk("sb_wdata",    last_wdata, 32'h8899AA12);
        chk("sb_waddr",    last_waddr, 32'h40);
        chk("sb_lat",      32'(lat), 32'd4);
        chk("sb_resp_data", data, 32'h0);
        xact(LW, 32'h40, 32'h0, 6'd5, lat, data, rtag, exc);
        chk("sb_readback", data, 32'h8899AA12);

        xact(SH, 32'h40, 32'hCAFE5678, 6'd8, lat, data, rtag, exc);
        chk("sh_wdata", last_wdata, 32'h88995678);
        chk("sh_lat",   32'(lat), 32'd4);

        // Flush a load while it waits for data.
        rd0 = rd_cnt; wr0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_op = LW; bus.req_addr = 32'h40; bus.req_tag = 6'd7;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("flush_wait_busy", 32'(bus.req_ready), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_to_idle", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("flush_no_resp", 32'(bus.resp_valid), 32'd0);
            tick();
        end
        xact(SW, 32'h44, 32'hDEADBEEF, 6'd10, lat, data, rtag, exc);
        chk("sw_lat",      32'(lat), 32'd2);
        chk("sw_wr_count", 32'(wr_cnt - wr0), 32'd1);
        chk("sw_rd_count", 32'(rd_cnt - rd0), 32'd1);
        chk("sw_wdata",    last_wdata, 32'hDEADBEEF);
        chk("sw_tag",      32'(rtag), 32'd10);

        // Flush a load in its issue cycle, then a fresh load must see correct data.
        bus.req_valid = 1'b1; bus.req_op = LW; bus.req_addr = 32'h40; bus.req_tag = 6'd11;
        tick();
        bus.req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_issue_idle", 32'(bus.req_ready), 32'd1);
        xact(LBU, 32'h44, 32'h0, 6'd12, lat, data, rtag, exc);
        chk("after_flush_lbu", data, 32'h000000EF);
        chk("after_flush_tag", 32'(rtag), 32'd12);
        xact(LB, 32'h47, 32'h0, 6'd13, lat, data, rtag, exc);
        chk("lb47_data", data, 32'hFFFFFFDE);

        // Flush coinciding with a request in IDLE blocks it.
        rd0 = rd_cnt;
        bus.req_valid = 1'b1; bus.req_op = LW; bus.req_addr = 32'h40;
        flush = 1'b1;
        tick();
        flush = 1'b0; bus.req_valid = 1'b0;
        chk("flush_accept_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) tick();
        chk("flush_accept_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("flush_accept_no_resp", 32'(bus.resp_valid), 32'd0);

        // Flush is ignored by a sub-word store.
        wr0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_op = SB; bus.req_addr = 32'h48;
        bus.req_wdata = 32'h77; bus.req_tag = 6'd14;
        tick();
        bus.req_valid = 1'b0;
        flush = 1'b1;
        repeat (3) tick();
        flush = 1'b0;
        chk("flush_store_resp", 32'(bus.resp_valid), 32'd1);
        chk("flush_store_data", bus.resp_data, 32'h0);
        tick();
        chk("flush_store_wr", 32'(wr_cnt - wr0), 32'd1);
        chk("flush_store_wdata", last_wdata, 32'h00000077);

        // Reset mid read-modify-write: no write afterwards.
        wr0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_op = SB; bus.req_addr = 32'h4C;
        bus.req_wdata = 32'h99; bus.req_tag = 6'd15;
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("midrst_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("midrst_ready",    32'(bus.req_ready), 32'd1);
        chk("midrst_no_resp",  32'(bus.resp_valid), 32'd0);

        // Response back-pressure.
        bus.resp_ready = 1'b0;
        issue(LW, 32'h44, 32'h0, 6'd9, lat);
        chk("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_data",  bus.resp_data, 32'hDEADBEEF);
            chk("bp_tag",   32'(bus.resp_tag), 32'd9);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        chk("bp_release", 32'(bus.req_ready), 32'd1);

        // Misaligned word store.
        rd0 = rd_cnt; wr0 = wr_cnt;
        xact(SW, 32'h41, 32'h11223344, 6'd16, lat, data, rtag, exc);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_sw_exc",  32'(exc), 32'd1);
        chk("mis_sw_lat",  32'(lat), 32'd1);
        chk("mis_sw_data", data, 32'h0);
        chk("mis_sw_nowr", 32'(wr_cnt - wr0), 32'd0);
        chk("mis_sw_nord", 32'(rd_cnt - rd0), 32'd0);
        xact(LW, 32'h40, 32'h0, 6'd17, lat, data, rtag, exc);
        chk("mis_sw_mem", data, 32'h88995678);
`else
        chk("mis_sw_exc",   32'(exc), 32'd0);
        chk("mis_sw_lat",   32'(lat), 32'd2);
        chk("mis_sw_wr",    32'(wr_cnt - wr0), 32'd1);
        chk("mis_sw_waddr", last_waddr, 32'h41);
        xact(LW, 32'h40, 32'h0, 6'd17, lat, data, rtag, exc);
        chk("mis_sw_mem", data, 32'h22334478);
`endif

        chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
